// File: rtl/ibex_instr_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ibex_instr_mem_responder                                     |
// | Description : Ibex instruction-fetch bus responder backed by a preloadable  |
// |               word memory, with fixed latency and bounded outstanding reqs. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module ibex_instr_mem_responder #(
  parameter int unsigned MemDepthWords  = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned RespLatency    = 2,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned ADDR_W        = $clog2(MemDepthWords)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  output logic              instr_err_o,
  input  logic              stall_gnt_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(MaxOutstanding + 1);

  logic [31:0]            mem [MemDepthWords];
  logic [29:0]            w_word;
  logic [ADDR_W-1:0]      w_idx;
  logic                   w_err;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_inflight;
  logic [RespLatency-1:0] r_valid;
  logic [RespLatency-1:0] r_err;
  logic [31:0]            r_data [RespLatency];

  // BaseAddr is word aligned, so the word offset can be taken on the upper bits only.
  assign w_word = instr_addr_i[31:2] - BaseAddr[31:2];
  assign w_idx  = w_word[ADDR_W-1:0];
  assign w_err  = (instr_addr_i[1:0] != 2'b00) | (instr_addr_i < BaseAddr) |
                  ({2'b00, w_word} >= 32'(MemDepthWords));

  // A response leaving this cycle frees its slot for an immediate regrant.
  assign w_inflight  = r_cnt - CNT_W'(r_valid[RespLatency-1]);
  assign instr_gnt_o = instr_req_i & ~stall_gnt_i & ~rst_i &
                       (w_inflight < CNT_W'(MaxOutstanding));

  always_ff @(posedge clk_i) begin
    if (mem_we_i) begin
      mem[mem_waddr_i] <= mem_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_cnt   <= '0;
    end else begin
      r_valid[0] <= instr_gnt_o;
      for (int i = 1; i < RespLatency; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
      case ({instr_gnt_o, r_valid[RespLatency-1]})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Payload carries no reset; it is qualified by r_valid at the output.
  always_ff @(posedge clk_i) begin
    if (instr_gnt_o) begin
      r_data[0] <= mem[w_idx];
      r_err[0]  <= w_err;
    end
    for (int i = 1; i < RespLatency; i++) begin
      r_data[i] <= r_data[i-1];
      r_err[i]  <= r_err[i-1];
    end
  end

  assign instr_rvalid_o = r_valid[RespLatency-1];
  assign instr_err_o    = instr_rvalid_o & r_err[RespLatency-1];
  assign instr_rdata_o  = (instr_rvalid_o & ~r_err[RespLatency-1]) ? r_data[RespLatency-1] : 32'h0;
  assign busy_o         = (r_cnt != '0);

endmodule
`default_nettype wire
